a_sink_fifo: RTL

//  Terminating consumer for the valid/stall pipeline chain. It accepts words from the

---
 rtl/a_pkg.sv | 11 +
 rtl/a_sink_ram.sv | 27 ++
 rtl/a_sink_fifo.sv | 77 +++++++
 3 files changed

// File: rtl/a_pkg.sv
// Shared defaults for the valid/stall pipeline chain and its sink.
package a_pkg;

    localparam int A_WORD  = 32;
    localparam int A_DEPTH = 4;

    function automatic int a_aw(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/a_sink_ram.sv
// Sink FIFO storage: synchronous write, asynchronous read, no reset.
module a_sink_ram
    import a_pkg::*;
#(
    parameter int WORD  = A_WORD,
    parameter int DEPTH = A_DEPTH,
    localparam int AW   = a_aw(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [WORD-1:0] wdata,
    input  logic [AW-1:0]   raddr,
    output logic [WORD-1:0] rdata
);

    logic [WORD-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/a_sink_fifo.sv
// Terminating consumer of the pipeline: stalls upstream when full and
// presents buffered words first-word-fall-through to a pop reader.
module a_sink_fifo
    import a_pkg::*;
#(
    parameter int WORD  = A_WORD,
    parameter int DEPTH = A_DEPTH,
    localparam int AW   = a_aw(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    input  logic [WORD-1:0] data_i,
    output logic            stall_o,
    output logic            v_o,
    output logic [WORD-1:0] data_o,
    input  logic            pop_i,
    output logic [AW:0]     count_o,
    output logic            err_o
);

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            err;
    logic            push;
    logic            pop;
    logic [WORD-1:0] rdata;

    // Stall depends only on registered occupancy, never on pop_i.
    assign stall_o = (count == FULL);
    assign v_o     = (count != '0);
    assign push    = v_i & ~stall_o;
    assign pop     = pop_i & v_o;
    assign count_o = count;
    assign err_o   = err;
    assign data_o  = v_o ? rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push & ~pop) begin
                count <= count + 1'b1;
            end else if (pop & ~push) begin
                count <= count - 1'b1;
            end
            if (pop_i & ~v_o) begin
                err <= 1'b1;
            end
        end
    end

    a_sink_ram #(
        .WORD  (WORD),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (data_i),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule
